// File: rtl/exa_crosb_packet_injector_if.sv
// ExaNet crossbar port handshake bundle: header, payload and footer phases
// share one 128-bit data bus, each with its own valid/ready pair.
interface exanet;
    logic         header_valid;
    logic         header_ready;
    logic         payload_valid;
    logic         payload_ready;
    logic         footer_valid;
    logic         footer_ready;
    logic [127:0] data;

    modport master (
        output header_valid, payload_valid, footer_valid, data,
        input  header_ready, payload_ready, footer_ready
    );

    modport slave (
        input  header_valid, payload_valid, footer_valid, data,
        output header_ready, payload_ready, footer_ready
    );
endinterface

// File: rtl/exa_crosb_packet_injector.sv
// ExaNet packet source: emits a programmed burst of packets with a
// deterministic payload pattern and an XOR checksum in each footer, so a
// downstream consumer can verify every packet on its own.
module exa_crosb_packet_injector #(
    parameter int         vc_num    = 4,
    parameter logic [7:0] input_id  = 8'd0,
    parameter int         max_words = 16,
    localparam int        vc_w      = (vc_num > 1) ? $clog2(vc_num) : 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_start,
    input  logic [15:0]       i_pkt_count,
    input  logic [21:0]       i_dst_coord,
    input  logic [13:0]       i_size,
    input  logic [vc_w-1:0]   i_vc,
    input  logic              i_prio,
    input  logic [7:0]        i_gap,
    exanet.master             exa,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_pkt_num
);

    typedef enum logic [2:0] {IDLE, HDR, PLD, FTR, GAP} state_t;

    localparam logic [13:0] clip_bytes = 14'(max_words * 16);
    localparam logic [13:0] clip_words = 14'(max_words);

    state_t      state;
    logic [15:0] count_left;
    logic [13:0] words;
    logic [13:0] word_idx;
    logic [7:0]  gap_left;
    logic [31:0] checksum;

    logic [13:0] size_eff;
    logic [13:0] raw_words;
    logic [13:0] new_words;
    logic [31:0] pkt_next;
    logic [31:0] csum_acc;

    function automatic logic [127:0] header_word(input logic [31:0] pkt,
                                                 input logic [13:0] size);
        return {16'h0, input_id, i_dst_coord, 2'(i_vc), i_prio, 17'h0,
                size, 16'h0, pkt};
    endfunction

    function automatic logic [127:0] payload_word(input logic [31:0] pkt,
                                                  input logic [31:0] idx);
        return {pkt, idx, ~pkt, ~idx};
    endfunction

    function automatic logic [127:0] footer_word(input logic [31:0] pkt,
                                                 input logic [31:0] csum);
        return {pkt, 64'h0, csum};
    endfunction

    // Packet geometry from the live inputs plus the running checksum including the word on the bus.
    always_comb begin
        size_eff  = (i_size > clip_bytes) ? clip_bytes : i_size;
        raw_words = ((i_size - 14'd1) >> 4) + 14'd1;
        new_words = '0;
        if (i_size != 14'd0) begin
            new_words = (raw_words > clip_words) ? clip_words : raw_words;
        end
        pkt_next = o_pkt_num + 32'd1;
        csum_acc = checksum ^ exa.data[127:96] ^ exa.data[95:64]
                 ^ exa.data[63:32] ^ exa.data[31:0];
    end

    // Burst sequencer; every bus output is registered and held until accepted.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state             <= IDLE;
            count_left        <= '0;
            words             <= '0;
            word_idx          <= '0;
            gap_left          <= '0;
            checksum          <= '0;
            exa.header_valid  <= 1'b0;
            exa.payload_valid <= 1'b0;
            exa.footer_valid  <= 1'b0;
            exa.data          <= '0;
            o_busy            <= 1'b0;
            o_done            <= 1'b0;
            o_pkt_num         <= '0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        if (i_pkt_count != 16'd0) begin
                            count_left       <= i_pkt_count;
                            o_busy           <= 1'b1;
                            state            <= HDR;
                            exa.header_valid <= 1'b1;
                            exa.data         <= header_word(o_pkt_num, size_eff);
                            words            <= new_words;
                            word_idx         <= '0;
                            checksum         <= '0;
                        end else begin
                            o_done <= 1'b1;
                        end
                    end
                end
                HDR: begin
                    if (exa.header_valid && exa.header_ready) begin
                        exa.header_valid <= 1'b0;
                        checksum         <= csum_acc;
                        if (words != 14'd0) begin
                            exa.payload_valid <= 1'b1;
                            exa.data          <= payload_word(o_pkt_num, 32'd0);
                            state             <= PLD;
                        end else begin
                            exa.footer_valid <= 1'b1;
                            exa.data         <= footer_word(o_pkt_num, csum_acc);
                            state            <= FTR;
                        end
                    end
                end
                PLD: begin
                    if (exa.payload_valid && exa.payload_ready) begin
                        checksum <= csum_acc;
                        if (word_idx == words - 14'd1) begin
                            exa.payload_valid <= 1'b0;
                            exa.footer_valid  <= 1'b1;
                            exa.data          <= footer_word(o_pkt_num, csum_acc);
                            state             <= FTR;
                        end else begin
                            word_idx <= word_idx + 14'd1;
                            exa.data <= payload_word(o_pkt_num, 32'(word_idx) + 32'd1);
                        end
                    end
                end
                FTR: begin
                    if (exa.footer_valid && exa.footer_ready) begin
                        exa.footer_valid <= 1'b0;
                        o_pkt_num        <= pkt_next;
                        count_left       <= count_left - 16'd1;
                        if (count_left == 16'd1) begin
                            state    <= IDLE;
                            o_done   <= 1'b1;
                            o_busy   <= 1'b0;
                            exa.data <= '0;
                        end else if (i_gap != 8'd0) begin
                            state    <= GAP;
                            gap_left <= i_gap;
                            exa.data <= '0;
                        end else begin
                            state            <= HDR;
                            exa.header_valid <= 1'b1;
                            exa.data         <= header_word(pkt_next, size_eff);
                            words            <= new_words;
                            word_idx         <= '0;
                            checksum         <= '0;
                        end
                    end
                end
                GAP: begin
                    if (gap_left <= 8'd1) begin
                        state            <= HDR;
                        exa.header_valid <= 1'b1;
                        exa.data         <= header_word(o_pkt_num, size_eff);
                        words            <= new_words;
                        word_idx         <= '0;
                        checksum         <= '0;
                    end else begin
                        gap_left <= gap_left - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exa_crosb_packet_injector.sv
// Directed bench for the packet injector: fixed vectors with hand-computed
// header/footer words, plus a bus monitor that checks payload pattern,
// footer checksum, stall stability and inter-packet gaps.
module tb_exa_crosb_packet_injector;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_start = 1'b0;
    logic [15:0] i_pkt_count = '0;
    logic [21:0] i_dst_coord = '0;
    logic [13:0] i_size = '0;
    logic [1:0]  i_vc = '0;
    logic        i_prio = 1'b0;
    logic [7:0]  i_gap = '0;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_pkt_num;

    int checks = 0;
    int errors = 0;

    exanet exa ();

    exa_crosb_packet_injector #(.vc_num(4), .input_id(8'd0), .max_words(16)) dut (
        .clk(clk), .resetn(resetn), .i_start(i_start), .i_pkt_count(i_pkt_count),
        .i_dst_coord(i_dst_coord), .i_size(i_size), .i_vc(i_vc), .i_prio(i_prio),
        .i_gap(i_gap), .exa(exa.master), .o_busy(o_busy), .o_done(o_done),
        .o_pkt_num(o_pkt_num)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] count, input logic [13:0] size,
                                 input logic [21:0] dst, input logic [1:0] vc,
                                 input logic prio, input logic [7:0] gap);
        i_pkt_count = count;
        i_size      = size;
        i_dst_coord = dst;
        i_vc        = vc;
        i_prio      = prio;
        i_gap       = gap;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic waitDone(input int bound, input string tag);
        int n = 0;
        while (!o_done && n < bound) begin
            tick();
            n++;
        end
        checkOutput(tag, 128'(o_done), 128'd1);
    endtask

    task automatic setReady(input logic r);
        exa.header_ready  = r;
        exa.payload_ready = r;
        exa.footer_ready  = r;
    endtask

    // Bus monitor state.
    int           hdr_cnt = 0;
    int           pld_cnt = 0;
    int           ftr_cnt = 0;
    int           idle_run = 0;
    int           gap_min = 1000;
    int           gap_max = -1;
    bit           counting = 0;
    bit           stall_pend = 0;
    logic [2:0]   stall_kind;
    logic [127:0] stall_data;
    logic [31:0]  cur_pkt;
    logic [31:0]  cur_k;
    logic [31:0]  csum;
    bit           rand_en = 0;

    function automatic logic [31:0] fold(input logic [127:0] d);
        return d[127:96] ^ d[95:64] ^ d[63:32] ^ d[31:0];
    endfunction

    // Observe handshakes mid-cycle; a valid&ready seen here is accepted at the next edge.
    always @(negedge clk) begin
        if (resetn) begin
            logic [2:0] kind;
            kind = {exa.header_valid, exa.payload_valid, exa.footer_valid};
            if (stall_pend) begin
                checkOutput("stall_valid", 128'(kind), 128'(stall_kind));
                checkOutput("stall_data", exa.data, stall_data);
            end
            stall_pend = 0;
            checkOutput("onehot_valid", 128'($countones(kind) <= 1), 128'd1);
            if (o_done) counting = 0;
            if (exa.header_valid && counting) begin
                if (idle_run < gap_min) gap_min = idle_run;
                if (idle_run > gap_max) gap_max = idle_run;
                counting = 0;
            end
            if (exa.header_valid && exa.header_ready) begin
                hdr_cnt++;
                cur_pkt = exa.data[31:0];
                csum    = fold(exa.data);
                cur_k   = 0;
            end
            if (exa.payload_valid && exa.payload_ready) begin
                checkOutput("payload_word", exa.data, {cur_pkt, cur_k, ~cur_pkt, ~cur_k});
                csum = csum ^ fold(exa.data);
                cur_k++;
                pld_cnt++;
            end
            if (exa.footer_valid && exa.footer_ready) begin
                checkOutput("footer_word", exa.data, {cur_pkt, 64'h0, csum});
                ftr_cnt++;
                counting = 1;
                idle_run = 0;
            end else if (kind == 3'b000 && counting) begin
                idle_run++;
            end
            if ((exa.header_valid && !exa.header_ready) ||
                (exa.payload_valid && !exa.payload_ready) ||
                (exa.footer_valid && !exa.footer_ready)) begin
                stall_pend = 1;
                stall_kind = kind;
                stall_data = exa.data;
            end
        end else begin
            stall_pend = 0;
            counting   = 0;
        end
    end

    // Randomised ready for the backpressure step.
    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            exa.header_ready  = 1'($urandom_range(0, 1));
            exa.payload_ready = 1'($urandom_range(0, 1));
            exa.footer_ready  = 1'($urandom_range(0, 1));
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int h0, p0, f0;
        setReady(1'b1);

        // Reset state.
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        checkOutput("rst_valids", 128'({exa.header_valid, exa.payload_valid, exa.footer_valid}), 128'd0);
        checkOutput("rst_data", exa.data, 128'd0);
        checkOutput("rst_busy_done", 128'({o_busy, o_done}), 128'd0);
        checkOutput("rst_pkt_num", 128'(o_pkt_num), 128'd0);

        // Basic packet: 64 bytes -> 4 payload words.
        $display("[TB] basic packet");
        applyStimulus(16'd1, 14'd64, 22'h15, 2'd2, 1'b1, 8'd0);
        checkOutput("basic_hv", 128'(exa.header_valid), 128'd1);
        checkOutput("basic_busy", 128'(o_busy), 128'd1);
        checkOutput("basic_header", exa.data, 128'h0000_0000_0056_8000_0040_0000_0000_0000);
        for (int k = 0; k < 4; k++) begin
            tick();
            checkOutput("basic_pv", 128'(exa.payload_valid), 128'd1);
        end
        tick();
        checkOutput("basic_fv", 128'(exa.footer_valid), 128'd1);
        checkOutput("basic_footer", exa.data, 128'h0000_0000_0000_0000_0000_0000_0016_8000);
        tick();
        checkOutput("basic_done", 128'({o_done, o_busy}), 128'b10);
        checkOutput("basic_pkt_num", 128'(o_pkt_num), 128'd1);

        // Zero-size packet: header straight to footer.
        $display("[TB] zero-size packet");
        applyStimulus(16'd1, 14'd0, 22'h3FFFFF, 2'd1, 1'b0, 8'd0);
        checkOutput("zero_header", exa.data, 128'h0000_00FF_FFFD_0000_0000_0000_0000_0001);
        tick();
        checkOutput("zero_valids", 128'({exa.header_valid, exa.payload_valid, exa.footer_valid}), 128'b001);
        checkOutput("zero_footer", exa.data, 128'h0000_0001_0000_0000_0000_0000_FFFD_00FE);
        tick();
        checkOutput("zero_done", 128'(o_done), 128'd1);

        // Clipped size: 300 bytes -> 16 words, size field 256.
        $display("[TB] clipped size");
        p0 = pld_cnt;
        applyStimulus(16'd1, 14'd300, 22'h0, 2'd0, 1'b0, 8'd0);
        checkOutput("clip_header", exa.data, 128'h0000_0000_0000_0000_0100_0000_0000_0002);
        waitDone(100, "clip_done");
        checkOutput("clip_words", 128'(pld_cnt - p0), 128'd16);

        // Backpressure from a fresh reset: 8 packets of 17 bytes.
        $display("[TB] backpressure");
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        h0 = hdr_cnt; p0 = pld_cnt; f0 = ftr_cnt;
        rand_en = 1;
        applyStimulus(16'd8, 14'd17, 22'h2A, 2'd3, 1'b0, 8'd0);
        waitDone(1000, "bp_done");
        rand_en = 0;
        tick();
        setReady(1'b1);
        checkOutput("bp_headers", 128'(hdr_cnt - h0), 128'd8);
        checkOutput("bp_words", 128'(pld_cnt - p0), 128'd16);
        checkOutput("bp_footers", 128'(ftr_cnt - f0), 128'd8);
        checkOutput("bp_pkt_num", 128'(o_pkt_num), 128'd8);
        checkOutput("bp_busy", 128'(o_busy), 128'd0);

        // Gap of 3 idle cycles between packets.
        $display("[TB] gap 3");
        gap_min = 1000; gap_max = -1;
        applyStimulus(16'd3, 14'd16, 22'h1, 2'd0, 1'b0, 8'd3);
        waitDone(100, "gap3_done");
        checkOutput("gap3_min", 128'(gap_min), 128'd3);
        checkOutput("gap3_max", 128'(gap_max), 128'd3);

        // Back-to-back packets.
        $display("[TB] gap 0");
        tick();
        gap_min = 1000; gap_max = -1;
        applyStimulus(16'd3, 14'd16, 22'h1, 2'd0, 1'b0, 8'd0);
        waitDone(100, "gap0_done");
        checkOutput("gap0_min", 128'(gap_min), 128'd0);
        checkOutput("gap0_max", 128'(gap_max), 128'd0);
        checkOutput("gap0_pkt_num", 128'(o_pkt_num), 128'd14);

        // Reset while in the payload phase.
        $display("[TB] abort");
        tick();
        applyStimulus(16'd2, 14'd64, 22'h7, 2'd1, 1'b1, 8'd0);
        tick();
        checkOutput("abort_in_pld", 128'(exa.payload_valid), 128'd1);
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        checkOutput("abort_valids", 128'({exa.header_valid, exa.payload_valid, exa.footer_valid}), 128'd0);
        checkOutput("abort_pkt_num", 128'(o_pkt_num), 128'd0);
        applyStimulus(16'd1, 14'd16, 22'h7, 2'd1, 1'b1, 8'd0);
        checkOutput("abort_restart_seq", 128'(exa.data[31:0]), 128'd0);
        waitDone(50, "abort_done");
        checkOutput("abort_pkt_after", 128'(o_pkt_num), 128'd1);

        // Zero-count burst: only a done pulse.
        $display("[TB] count zero");
        tick();
        applyStimulus(16'd0, 14'd16, 22'h0, 2'd0, 1'b0, 8'd0);
        checkOutput("cnt0_done", 128'({o_done, o_busy, exa.header_valid}), 128'b100);
        tick();
        checkOutput("cnt0_quiet", 128'({o_done, o_busy, exa.header_valid}), 128'b000);

        // Start while busy is ignored.
        $display("[TB] start while busy");
        f0 = ftr_cnt;
        applyStimulus(16'd2, 14'd0, 22'h0, 2'd0, 1'b0, 8'd0);
        applyStimulus(16'd5, 14'd0, 22'h0, 2'd0, 1'b0, 8'd0);
        waitDone(50, "busy_done");
        checkOutput("busy_footers", 128'(ftr_cnt - f0), 128'd2);
        checkOutput("busy_pkt_num", 128'(o_pkt_num), 128'd3);
        tick();
        checkOutput("busy_idle", 128'({o_busy, exa.header_valid}), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
